// File: rtl/midi_activity_sched_if.sv
// midi_activity_sched_if
//   Bundles the event strobes, the snapshot handshake and the LED/activity
//   outputs of midi_activity_sched.
//   master : the event/shifter side. It drives in_evt, out_evt and snap_req.
//   slave  : the scheduler. It drives snap_ack, in_led, out_led and act.
//   in_evt / out_evt : 16-bit single-cycle strobes, one bit per MIDI port.
//   snap_req / snap_ack : 4-phase snapshot request/acknowledge levels.
//   in_led / out_led : 16-bit latched activity snapshots.
//   act : 32-bit live activity, bits 0-15 for inputs and 16-31 for outputs.
interface midi_activity_sched_if;
  logic [15:0] in_evt;
  logic [15:0] out_evt;
  logic        snap_req;
  logic        snap_ack;
  logic [15:0] in_led;
  logic [15:0] out_led;
  logic [31:0] act;

  modport master (
    output in_evt, out_evt, snap_req,
    input  snap_ack, in_led, out_led, act
  );

  modport slave (
    input  in_evt, out_evt, snap_req,
    output snap_ack, in_led, out_led, act
  );
endinterface

// File: rtl/midi_activity_sched.sv
// midi_activity_sched
//   Turns single-cycle MIDI port strobes into visible LED hold-time flashes.
//   There are 32 hold counters: channels 0-15 take in_evt and channels 16-31
//   take out_evt. A single sweep, triggered by a decay tick, ages one counter
//   per cycle. The LED shifter receives stable snapshots through a 4-phase
//   request/acknowledge.
//   clk : system clock.
//   rst : asynchronous, active-high reset.
//   bus : midi_activity_sched_if.slave. It carries the strobes, the snapshot
//         handshake, the LED snapshots and live activity.
//   TICK_DIV : clk cycles per decay tick. Must be 64 or more.
//   HOLD     : ticks a channel stays lit after its last event.
//   CW       : width of the hold counter.
module midi_activity_sched #(
  parameter int TICK_DIV = 12000,
  parameter int HOLD     = 30,
  parameter int CW       = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  midi_activity_sched_if.slave        bus
);
  localparam int NCH = 32;
  localparam int PW  = $clog2(TICK_DIV);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t          state_q, state_d;
  logic [4:0]      idx_q, idx_d;
  logic            pend_q, pend_d;
  logic [PW-1:0]   pre_q;
  logic            tick;
  logic [CW-1:0]   cnt_q [NCH];
  logic [NCH-1:0]  evt;
  logic [NCH-1:0]  act;
  logic            req_q;
  logic            snap_ack_q;
  logic [15:0]     in_led_q, out_led_q;

  assign evt  = {bus.out_evt, bus.in_evt};
  assign tick = (pre_q == PW'(TICK_DIV - 1));

  // Prescaler: 0..TICK_DIV-1. The tick is high during the last count, so
  // the FSM sees it on the wrap edge.
  // NOTE: sequential state uses non-blocking (<=) assignments only. This
  // makes every flop sample values from before the edge and prevents races
  // that depend on evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre_q <= '0;
    else     pre_q <= tick ? '0 : pre_q + PW'(1);
  end

  // Decay FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
    end
  end

  // Decay FSM: next state. A tick that arrives mid-sweep is remembered once
  // and starts the next sweep right after the current one ends.
  // NOTE: every output of this block is assigned a default first. This
  // guarantees that no path leaves a value unassigned and so no latch is
  // inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (tick || pend_q) begin
          state_d = SWEEP;
          idx_d   = '0;
          pend_d  = 1'b0;
        end
      end
      SWEEP: begin
        idx_d = idx_q + 5'd1;
        if (tick) pend_d = 1'b1;
        if (idx_q == 5'd31) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold counters. An event reloads the counter in any state, and it takes
  // priority over the decrement the sweep would apply to the same channel.
  // NOTE: this counter array is reset explicitly because a reset must
  // leave every LED dark. A storage array that is never read before it is
  // written would not need a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (evt[i])
          cnt_q[i] <= CW'(HOLD);
        else if (state_q == SWEEP && idx_q == 5'(i) && cnt_q[i] != '0)
          cnt_q[i] <= cnt_q[i] - CW'(1);
      end
    end
  end

  always_comb begin
    act = '0;
    for (int i = 0; i < NCH; i++) act[i] = (cnt_q[i] != '0);
  end

  // Snapshot handshake. A request that arrives while the acknowledge is low
  // latches act. The acknowledge drops one edge after the request is
  // sampled low (req_q), so even a one-cycle request produces a two-cycle
  // acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q      <= 1'b0;
      snap_ack_q <= 1'b0;
      in_led_q   <= '0;
      out_led_q  <= '0;
    end else begin
      req_q <= bus.snap_req;
      if (bus.snap_req && !snap_ack_q) begin
        in_led_q   <= act[15:0];
        out_led_q  <= act[31:16];
        snap_ack_q <= 1'b1;
      end else if (snap_ack_q && !req_q) begin
        snap_ack_q <= 1'b0;
      end
    end
  end

  assign bus.act      = act;
  assign bus.snap_ack = snap_ack_q;
  assign bus.in_led   = in_led_q;
  assign bus.out_led  = out_led_q;
endmodule

// File: tb/tb_midi_activity_sched.sv
// tb_midi_activity_sched
//   Directed bench for midi_activity_sched with TICK_DIV=64, HOLD=3, CW=5.
//   Edge 1 is the first rising clk edge after reset release. With these
//   parameters, the sweeps start on edges 64, 128 and 192, and channel k
//   is aged on edges 65+k, 129+k and 193+k.
module tb_midi_activity_sched;
  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   bad    = 0;
  int   edge_n = 0;

  midi_activity_sched_if bus();

  midi_activity_sched #(
    .TICK_DIV(64),
    .HOLD    (3),
    .CW      (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic goto_edge(input int n);
    if (n > edge_n) adv(n - edge_n);
  endtask

  task automatic do_reset();
    bus.in_evt   = '0;
    bus.out_evt  = '0;
    bus.snap_req = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    edge_n = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus.act !== 32'h0) begin
      bad++; $display("FAIL reset_act got=%h exp=%h", bus.act, 32'h0);
    end
    total++;
    if ({bus.snap_ack, bus.in_led, bus.out_led} !== 33'h0) begin
      bad++; $display("FAIL reset_snap got ack=%b in=%h out=%h exp all 0",
                      bus.snap_ack, bus.in_led, bus.out_led);
    end
  endtask

  task automatic test_single_event();
    do_reset();
    goto_edge(9);
    bus.in_evt = 16'h0020;
    adv(1);
    bus.in_evt = '0;
    total++;
    if (bus.act !== 32'h0000_0020) begin
      bad++; $display("FAIL single_lit got=%h exp=%h", bus.act, 32'h0000_0020);
    end
    goto_edge(197);
    total++;
    if (bus.act !== 32'h0000_0020) begin
      bad++; $display("FAIL single_hold got=%h exp=%h", bus.act, 32'h0000_0020);
    end
    adv(1);
    total++;
    if (bus.act !== 32'h0) begin
      bad++; $display("FAIL single_clear got=%h exp=%h", bus.act, 32'h0);
    end
  endtask

  // Channel 18 is loaded at edge 10 and reloaded at edge 83, when the
  // sweep ages it. If the reload wins, the counter goes 3 -> dark at 275.
  // If the decrement wins, the channel goes dark at edge 211.
  task automatic test_reload_wins();
    do_reset();
    goto_edge(9);
    bus.out_evt = 16'h0004;
    adv(1);
    bus.out_evt = '0;
    goto_edge(82);
    bus.out_evt = 16'h0004;
    adv(1);
    bus.out_evt = '0;
    total++;
    if (bus.act !== 32'h0004_0000) begin
      bad++; $display("FAIL reload_lit got=%h exp=%h", bus.act, 32'h0004_0000);
    end
    goto_edge(274);
    total++;
    if (bus.act !== 32'h0004_0000) begin
      bad++; $display("FAIL reload_hold got=%h exp=%h", bus.act, 32'h0004_0000);
    end
    adv(1);
    total++;
    if (bus.act !== 32'h0) begin
      bad++; $display("FAIL reload_clear got=%h exp=%h", bus.act, 32'h0);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    goto_edge(9);
    bus.in_evt  = 16'hFFFF;
    bus.out_evt = 16'hFFFF;
    adv(1);
    bus.in_evt  = '0;
    bus.out_evt = '0;
    total++;
    if (bus.act !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL simul_all got=%h exp=%h", bus.act, 32'hFFFF_FFFF);
    end
    goto_edge(192);
    total++;
    if (bus.act !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL simul_hold got=%h exp=%h", bus.act, 32'hFFFF_FFFF);
    end
    goto_edge(200);
    total++;
    if (bus.act !== 32'hFFFF_FF00) begin
      bad++; $display("FAIL simul_mid got=%h exp=%h", bus.act, 32'hFFFF_FF00);
    end
    goto_edge(223);
    total++;
    if (bus.act !== 32'h8000_0000) begin
      bad++; $display("FAIL simul_last got=%h exp=%h", bus.act, 32'h8000_0000);
    end
    adv(1);
    total++;
    if (bus.act !== 32'h0) begin
      bad++; $display("FAIL simul_clear got=%h exp=%h", bus.act, 32'h0);
    end
  endtask

  task automatic test_snapshot_stability();
    do_reset();
    goto_edge(9);
    bus.in_evt = 16'h0001;
    adv(1);
    bus.in_evt = '0;
    goto_edge(19);
    bus.snap_req = 1'b1;
    adv(1);
    total++;
    if ({bus.snap_ack, bus.in_led, bus.out_led} !== {1'b1, 16'h0001, 16'h0000}) begin
      bad++; $display("FAIL snap_latch got ack=%b in=%h out=%h exp ack=1 in=0001 out=0000",
                      bus.snap_ack, bus.in_led, bus.out_led);
    end
    for (int i = 0; i < 200; i++) begin
      adv(1);
      total++;
      if ({bus.snap_ack, bus.in_led[0]} !== 2'b11) begin
        bad++; $display("FAIL snap_stable edge=%0d got ack=%b led0=%b exp ack=1 led0=1",
                        edge_n, bus.snap_ack, bus.in_led[0]);
      end
    end
    total++;
    if (bus.act[0] !== 1'b0) begin
      bad++; $display("FAIL snap_decayed got=%b exp=%b", bus.act[0], 1'b0);
    end
    bus.snap_req = 1'b0;
    adv(1);
    total++;
    if (bus.snap_ack !== 1'b1) begin
      bad++; $display("FAIL snap_ack_linger got=%b exp=%b", bus.snap_ack, 1'b1);
    end
    adv(1);
    total++;
    if (bus.snap_ack !== 1'b0) begin
      bad++; $display("FAIL snap_ack_drop got=%b exp=%b", bus.snap_ack, 1'b0);
    end
    bus.snap_req = 1'b1;
    adv(1);
    total++;
    if ({bus.snap_ack, bus.in_led} !== {1'b1, 16'h0000}) begin
      bad++; $display("FAIL snap_relatch got ack=%b in=%h exp ack=1 in=0000",
                      bus.snap_ack, bus.in_led);
    end
    bus.snap_req = 1'b0;
    adv(3);
  endtask

  task automatic test_handshake();
    do_reset();
    goto_edge(4);
    bus.snap_req = 1'b1;
    adv(1);
    bus.snap_req = 1'b0;
    total++;
    if (bus.snap_ack !== 1'b1) begin
      bad++; $display("FAIL hs_ack1 got=%b exp=%b", bus.snap_ack, 1'b1);
    end
    adv(1);
    total++;
    if (bus.snap_ack !== 1'b1) begin
      bad++; $display("FAIL hs_ack2 got=%b exp=%b", bus.snap_ack, 1'b1);
    end
    adv(1);
    total++;
    if (bus.snap_ack !== 1'b0) begin
      bad++; $display("FAIL hs_ack3 got=%b exp=%b", bus.snap_ack, 1'b0);
    end
    goto_edge(9);
    bus.snap_req = 1'b1;
    adv(1);
    goto_edge(11);
    bus.in_evt = 16'h0008;
    adv(1);
    bus.in_evt = '0;
    total++;
    if (bus.act !== 32'h0000_0008) begin
      bad++; $display("FAIL hs_act got=%h exp=%h", bus.act, 32'h0000_0008);
    end
    goto_edge(30);
    total++;
    if ({bus.snap_ack, bus.in_led} !== {1'b1, 16'h0000}) begin
      bad++; $display("FAIL hs_no_relatch got ack=%b in=%h exp ack=1 in=0000",
                      bus.snap_ack, bus.in_led);
    end
    bus.snap_req = 1'b0;
    adv(2);
    total++;
    if (bus.snap_ack !== 1'b0) begin
      bad++; $display("FAIL hs_release got=%b exp=%b", bus.snap_ack, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    goto_edge(9);
    bus.in_evt = 16'hF00F;
    adv(1);
    bus.in_evt = '0;
    goto_edge(69);
    bus.snap_req = 1'b1;
    adv(1);
    total++;
    if (bus.in_led !== 16'hF00F) begin
      bad++; $display("FAIL ar_snap got=%h exp=%h", bus.in_led, 16'hF00F);
    end
    goto_edge(76);
    total++;
    if (bus.act !== 32'h0000_F00F) begin
      bad++; $display("FAIL ar_pre got=%h exp=%h", bus.act, 32'h0000_F00F);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({bus.act, bus.snap_ack, bus.in_led, bus.out_led} !== 65'h0) begin
      bad++; $display("FAIL ar_async got act=%h ack=%b in=%h out=%h exp all 0",
                      bus.act, bus.snap_ack, bus.in_led, bus.out_led);
    end
    bus.snap_req = 1'b0;
    rst = 1'b0;
    edge_n = 0;
    // First sweep after release starts at edge 64. Therefore a load at
    // edge 64 is aged on edges 65, 129 and 193.
    goto_edge(63);
    bus.in_evt = 16'h0001;
    adv(1);
    bus.in_evt = '0;
    goto_edge(192);
    total++;
    if (bus.act !== 32'h0000_0001) begin
      bad++; $display("FAIL ar_tick_hold got=%h exp=%h", bus.act, 32'h0000_0001);
    end
    adv(1);
    total++;
    if (bus.act !== 32'h0) begin
      bad++; $display("FAIL ar_tick_clear got=%h exp=%h", bus.act, 32'h0);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_evt   = '0;
    bus.out_evt  = '0;
    bus.snap_req = 1'b0;
    adv(2);
    test_reset();
    test_single_event();
    test_reload_wins();
    test_simultaneous();
    test_snapshot_stability();
    test_handshake();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
